// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the fifo block.
//   DEFAULT_BUFFER_SIZE : default FIFO depth in entries (power of two, >= 2)
//   DEFAULT_DATA_WIDTH  : default entry width in bits
//   clog2()             : pointer width needed to address a given depth
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_BUFFER_SIZE = 128;
    localparam int DEFAULT_DATA_WIDTH  = 32;

    // Ceiling log2, usable in constant expressions (parameter/localparam).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Dual-port register array backing the FIFO: one synchronous write port and
// one asynchronous (zero-latency) read port.
// Ports:
//   clk_i    : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinationally follows raddr_i
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_BUFFER_SIZE,
    parameter int WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_W = clog2(DEFAULT_BUFFER_SIZE)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage arrays carry no reset; valid/invalid is tracked by the
    // pointers and counter, so resetting every word would only cost logic.
    // NOTE: sequential state is always assigned with <= so all flops sample
    // their inputs from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Single-clock show-ahead FIFO with an occupancy counter.
// Ports:
//   clock_in       : sole clock, rising edge
//   rst_in_n       : asynchronous active-low reset of pointers and counter
//   clock_out      : legacy pin, no functional effect
//   rst_out_n      : legacy pin, no functional effect
//   data_in        : write data
//   data_in_valid  : write request (dropped while data_in_full)
//   data_in_full   : FIFO holds BUFFER_SIZE entries
//   data_out       : oldest entry, no read latency
//   data_out_valid : FIFO holds at least one entry
//   data_out_ack   : pop the entry on data_out (ignored while empty)
// -----------------------------------------------------------------------------
module fifo
    import fifo_pkg::*;
#(
    parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock_in,
    input  logic                  rst_in_n,
    input  logic                  clock_out,
    input  logic                  rst_out_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ack
);

    localparam int PTR_W = clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_SIZE);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             wr_en;
    logic             rd_en;

    // Legacy pins are kept on the boundary but intentionally unused.
    logic unused_legacy_pins;
    assign unused_legacy_pins = clock_out ^ rst_out_n;

    // Flags decode only registered state, so there is no input-to-output path.
    assign data_in_full   = (count_q == FULL_COUNT);
    assign data_out_valid = (count_q != '0);

    // A pop needs a stored entry, so write+pop on an empty FIFO is a write
    // only; a write needs space, so write+pop on a full FIFO is a pop only.
    assign wr_en = data_in_valid & ~data_in_full;
    assign rd_en = data_out_ack  &  data_out_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Power-of-two depth: natural pointer overflow is the modulo wrap.
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .DEPTH  (BUFFER_SIZE),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk_i   (clock_in),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

endmodule : fifo

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo
// Self-checking bench for fifo: vector table for the basic stream, directed
// sequences for full/wrap/reset corners, and random traffic compared against
// a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fifo;

    localparam int DEPTH = 128;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_full;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ack;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO contents, oldest first.
    logic [DW-1:0] model_q [$];

    fifo #(
        .BUFFER_SIZE (DEPTH),
        .DATA_WIDTH  (DW)
    ) dut (
        .clock_in       (clk),
        .rst_in_n       (rst_n),
        .clock_out      (~clk),
        .rst_out_n      (1'b0),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_full   (data_in_full),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ack   (data_out_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, DW'(data_out_valid), DW'(model_q.size() != 0));
        check({tag, ".full"},  DW'(data_in_full),   DW'(model_q.size() == DEPTH));
        if (model_q.size() != 0) check({tag, ".data"}, data_out, model_q[0]);
    endtask

    // One clock: drive inputs, let the edge happen, update the model from the
    // pre-edge occupancy, then sample outputs 1 time unit after the edge.
    task automatic cycle(input logic [DW-1:0] d, input logic v, input logic a, input string tag);
        bit do_wr;
        bit do_pop;
        data_in       = d;
        data_in_valid = v;
        data_out_ack  = a;
        do_wr  = v && (model_q.size() < DEPTH);
        do_pop = a && (model_q.size() != 0);
        @(posedge clk);
        if (do_pop) void'(model_q.pop_front());
        if (do_wr)  model_q.push_back(d);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic [DW-1:0] din;
        logic          vin;
        logic          ack;
        logic          exp_valid;
        logic          exp_full;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [DW-1:0] v;
        int            n;

        // Stream of 8 one-hot writes, then 8 acknowledged pops.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{din: DW'(1) << i, vin: 1'b1, ack: 1'b0,
                        exp_valid: 1'b1, exp_full: 1'b0, exp_dout: 32'h1};
        end
        for (int i = 0; i < 8; i++) begin
            vecs[8+i] = '{din: '0, vin: 1'b0, ack: 1'b1,
                          exp_valid: (i < 7), exp_full: 1'b0,
                          exp_dout: (i < 7) ? (DW'(1) << (i + 1)) : '0};
        end

        data_in       = '0;
        data_in_valid = 1'b0;
        data_out_ack  = 1'b0;
        rst_n         = 1'b0;

        // Reset, then idle.
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", DW'(data_out_valid), '0);
        check("reset.full",  DW'(data_in_full),   '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b0, "idle");
        check("idle.valid", DW'(data_out_valid), '0);

        // Table-driven stream: data_out shows 0x1 throughout the writes,
        // then each popped value in order.
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].din, vecs[i].vin, vecs[i].ack, "vec");
            check($sformatf("vec%0d.valid", i), DW'(data_out_valid), DW'(vecs[i].exp_valid));
            check($sformatf("vec%0d.full", i),  DW'(data_in_full),   DW'(vecs[i].exp_full));
            if (vecs[i].exp_valid) check($sformatf("vec%0d.data", i), data_out, vecs[i].exp_dout);
        end

        // Fill to capacity, drop an overflow write, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(DW'(i), 1'b1, 1'b0, "fill");
        check("fill.full", DW'(data_in_full), 32'h1);
        cycle(32'hDEADBEEF, 1'b1, 1'b0, "overflow");
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d", i), data_out, DW'(i));
            cycle('0, 1'b0, 1'b1, "drain");
        end
        check("drain.valid", DW'(data_out_valid), '0);

        // Write+ack on an empty FIFO: write only.
        cycle(32'hA5A5_0001, 1'b1, 1'b1, "empty_wr_ack");
        check("empty_wr_ack.data", data_out, 32'hA5A5_0001);
        cycle('0, 1'b0, 1'b1, "empty_wr_ack.pop");

        // Write+ack on a full FIFO: pop only, the write is dropped.
        for (int i = 0; i < DEPTH; i++) cycle(32'h1000 + DW'(i), 1'b1, 1'b0, "refill");
        cycle(32'hDEADBEEF, 1'b1, 1'b1, "full_wr_ack");
        check("full_wr_ack.data", data_out, 32'h1001);
        check("full_wr_ack.full", DW'(data_in_full), '0);
        while (model_q.size() != 0) cycle('0, 1'b0, 1'b1, "refill.drain");

        // Hold occupancy at 5 across pointer wrap.
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(32'h2000 + DW'(n), 1'b1, 1'b0, "hold.fill");
            n++;
        end
        for (int i = 0; i < 300; i++) begin
            v = 32'h2000 + DW'(i);
            check("hold.order", data_out, v);
            cycle(32'h2000 + DW'(n), 1'b1, 1'b1, "hold");
            n++;
            check("hold.valid", DW'(data_out_valid), 32'h1);
            check("hold.full",  DW'(data_in_full),   '0);
        end
        check("hold.occupancy", DW'(model_q.size()), 32'd5);
        while (model_q.size() != 0) cycle('0, 1'b0, 1'b1, "hold.drain");

        // Mid-operation reset pulse between edges.
        for (int i = 0; i < 10; i++) cycle(32'h3000 + DW'(i), 1'b1, 1'b0, "prerst");
        data_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.valid", DW'(data_out_valid), '0);
        check("midrst.full",  DW'(data_in_full),   '0);
        model_q.delete();
        #1;
        rst_n = 1'b1;
        cycle(32'h55, 1'b1, 1'b0, "postrst");
        check("postrst.data", data_out, 32'h55);
        cycle('0, 1'b0, 1'b1, "postrst.pop");
        check("postrst.empty", DW'(data_out_valid), '0);

        // Random traffic in phases biased toward filling and draining.
        for (int phase = 0; phase < 6; phase++) begin
            int wr_pct;
            int ack_pct;
            wr_pct  = (phase % 2 == 0) ? 90 : 20;
            ack_pct = (phase % 2 == 0) ? 15 : 85;
            for (int i = 0; i < 400; i++) begin
                cycle($urandom(),
                      ($urandom_range(99) < wr_pct),
                      ($urandom_range(99) < ack_pct),
                      "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo
